// File: rtl/ifq_prefetch_if.sv
// ---------------------------------------------------------------------------
// ifq_prefetch_if
// Bundles the two handshakes of the instruction prefetch queue.
//   Memory side : mem_req/mem_addr (queue -> memory), mem_ack/mem_rdata back.
//   IF side     : if_valid/if_instr/if_pc (queue -> IF), if_ready back.
//   Redirect    : pc_src/pc_addr (pipeline -> queue).
// Modports:
//   master : the prefetch queue itself.
//   slave  : the surrounding memory / pipeline (or a testbench).
// ---------------------------------------------------------------------------
interface ifq_prefetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        pc_src;
  logic [31:0] pc_addr;

  modport master (
    output mem_req, mem_addr, if_valid, if_instr, if_pc,
    input  mem_ack, mem_rdata, if_ready, pc_src, pc_addr
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_instr, if_pc,
    output mem_ack, mem_rdata, if_ready, pc_src, pc_addr
  );
endinterface

// File: rtl/ifq_prefetch.sv
// ---------------------------------------------------------------------------
// ifq_prefetch
// Instruction prefetch queue in front of the IF stage. Fetches sequential
// words over a req/ack memory port, buffers up to DEPTH {pc, instr} entries
// and hands them to IF over valid/ready. A pc_src strobe flushes the queue
// and restarts fetching at the (word-aligned) branch target.
//
// Parameters:
//   DEPTH    : queue entries, power of two, 2..16.
//   RESET_PC : first fetch address after reset.
// Ports:
//   clk      : clock, rising edge.
//   rst_n    : asynchronous active-low reset.
//   bus      : ifq_prefetch_if.master (memory port, IF port, redirect).
//   q_count  : current occupancy, 0..DEPTH (diagnostic).
// Optional feature:
//   IFQ_BYPASS_EN : when defined, a word arriving into an empty queue is
//                   presented to IF combinationally in its ack cycle.
// ---------------------------------------------------------------------------
module ifq_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ifq_prefetch_if.master           bus,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fpc;
  logic [1:0]    r_state;
  logic [31:0]   r_hold_pc;
  logic [31:0]   r_hold_instr;

  logic          w_empty;
  logic          w_req;
  logic          w_xfer;
  logic          w_byp;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_instr;
  logic [31:0]   w_pc;
  logic [CW-1:0] w_count_next;
  logic [1:0]    w_state_next;

  assign w_empty = (r_count == '0);

  // pc_src kills the request in its own cycle, so an ack there never counts.
  assign w_req  = !bus.pc_src && (r_state == ST_RUN) && (r_count != FULL_CNT);
  assign w_xfer = w_req && bus.mem_ack;

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty && w_xfer;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid = !bus.pc_src && (!w_empty || w_byp);
  // Pop only removes a stored entry; a bypassed word never occupies a slot.
  assign w_pop   = w_valid && bus.if_ready && !w_empty;
  assign w_push  = w_xfer && !(w_byp && bus.if_ready);

  // Head selection: stored entry, else bypassed word, else last shown values.
  always_comb begin
    w_instr = r_hold_instr;
    w_pc    = r_hold_pc;
    if (!w_empty) begin
      w_instr = r_mem_instr[r_rd_ptr];
      w_pc    = r_mem_pc[r_rd_ptr];
    end else if (w_byp) begin
      w_instr = bus.mem_rdata;
      w_pc    = r_fpc;
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.pc_src) begin
      w_state_next = ST_REDIR;
    end else begin
      case (r_state)
        ST_RUN:   if (w_count_next == FULL_CNT) w_state_next = ST_FULL;
        ST_FULL:  if (w_pop) w_state_next = ST_RUN;
        ST_REDIR: w_state_next = ST_RUN;
        default:  w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_fpc        <= RESET_PC;
      r_state      <= ST_RUN;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_valid) begin
        r_hold_pc    <= w_pc;
        r_hold_instr <= w_instr;
      end
      if (bus.pc_src) begin
        // Flush: discard everything between rd and wr without touching storage.
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
        r_fpc    <= {bus.pc_addr[31:2], 2'b00};
      end else begin
        r_count <= w_count_next;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_xfer) r_fpc    <= r_fpc + 32'd4;
      end
    end
  end

  // Storage has no reset; rst_n gating keeps a transfer caught by reset from
  // landing in the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fpc;
      r_mem_instr[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req  = w_req;
  assign bus.mem_addr = r_fpc;
  assign bus.if_valid = w_valid;
  assign bus.if_instr = w_instr;
  assign bus.if_pc    = w_pc;
  assign q_count      = r_count;

endmodule

// File: tb/tb_ifq_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifq_prefetch
// Drives ifq_prefetch with directed phases followed by random stimulus and
// compares every output, every cycle, against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ifq_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [$clog2(DEPTH):0] q_count;

  ifq_prefetch_if bus();

  ifq_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;
  bit          m_redir;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc        = RPC;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0;
    m_redir      = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the
  // combinational view 1ns later, advance the model past the rising edge.
  task automatic step(input bit src, input logic [31:0] addr, input bit ack, input bit rdy);
    logic [31:0] rdata;
    int          n;
    bit          exp_req, xfer, byp, exp_valid;
    logic [31:0] exp_instr, exp_pc;
    rdata         = $urandom;
    bus.pc_src    = src;
    bus.pc_addr   = addr;
    bus.mem_ack   = ack;
    bus.if_ready  = rdy;
    bus.mem_rdata = rdata;
    #1;
    n         = mq.size();
    exp_req   = !src && !m_redir && (n < DEPTH);
    xfer      = exp_req && ack;
    byp       = BYP && (n == 0) && xfer;
    exp_valid = !src && (n > 0 || byp);
    if (n > 0) begin
      exp_instr = mq[0].instr;
      exp_pc    = mq[0].pc;
    end else if (byp) begin
      exp_instr = rdata;
      exp_pc    = m_fpc;
    end else begin
      exp_instr = m_last_instr;
      exp_pc    = m_last_pc;
    end
    chk("mem_req",  {31'b0, bus.mem_req}, {31'b0, exp_req});
    chk("mem_addr", bus.mem_addr, m_fpc);
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, exp_valid});
    chk("q_count",  32'(q_count), 32'(n));
    if (!src) begin
      chk("if_instr", bus.if_instr, exp_instr);
      chk("if_pc",    bus.if_pc, exp_pc);
    end
    if (src) begin
      mq.delete();
      m_fpc   = {addr[31:2], 2'b00};
      m_redir = 1'b1;
      $display("redirect target=%08h", m_fpc);
    end else begin
      m_redir = 1'b0;
      if (exp_valid) begin
        m_last_pc    = exp_pc;
        m_last_instr = exp_instr;
      end
      if (exp_valid && rdy) begin
        $display("pop pc=%08h instr=%08h%s", exp_pc, exp_instr, (n == 0) ? " (bypass)" : "");
        if (n > 0) void'(mq.pop_front());
      end
      if (xfer && !(byp && rdy)) mq.push_back('{pc: m_fpc, instr: rdata});
      if (xfer) m_fpc = m_fpc + 32'd4;
    end
    @(negedge clk);
  endtask

  // Reset entered at a falling edge; optionally with a transfer in flight.
  task automatic do_reset(input bit mid);
    bus.pc_src   = 1'b0;
    bus.if_ready = 1'b0;
    bus.mem_ack  = mid;
    #2;
    rst_n = 1'b0;
    #1;
    bus.mem_ack = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_req",  {31'b0, bus.mem_req}, 32'd1);
    chk("rst_mem_addr", bus.mem_addr, RPC);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc",    bus.if_pc, 32'h0);
    chk("rst_q_count",  32'(q_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released%s", mid ? " (after mid-transfer assert)" : "");
  endtask

  initial begin
    int rdy_pct;
    bus.pc_src    = 1'b0;
    bus.pc_addr   = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.if_ready  = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Zero-wait streaming from RESET_PC.
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Stall IF: fill to DEPTH, request drops.
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    // Single pop frees a slot; refill.
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    // Drop to 3 words, then redirect with an ack in the same cycle.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h2003, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Address wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Back-to-back redirects, latest target wins.
    step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
    step(1'b1, 32'h0000_5006, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    // Reset with a transfer in flight.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    // Empty-queue ack with IF ready (bypass-relevant case).
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic; IF readiness varies in blocks to exercise full/empty.
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) rdy_pct = $urandom_range(0, 100);
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) < rdy_pct));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifq_prefetch.md
# ifq_prefetch

Instruction prefetch queue sitting directly upstream of the IF stage, between instruction memory and the CPU fetch path. Fetches sequential words ahead of the pipeline over a req/ack memory port, buffers up to DEPTH words with their PCs, and presents them to IF with a valid/ready handshake. A taken branch (`pc_src`) flushes the queue and restarts fetching at the branch target.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0: first fetch address after reset.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: fetch request; `mem_addr` stays stable while it is high.
- `mem_addr` out 32: word-aligned fetch address.
- `mem_ack` in 1: transfer completes in any cycle where `mem_req && mem_ack`.
- `mem_rdata` in 32: instruction word; valid in the ack cycle.
- `if_valid` out 1: `if_instr`/`if_pc` hold a valid entry.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: address of the head instruction.
- `if_ready` in 1: IF accepts; pop occurs when `if_valid && if_ready`.
- `pc_src` in 1: redirect strobe, one cycle.
- `pc_addr` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `q_count` out log2(DEPTH)+1: current occupancy (diagnostic).

## Operation
- Storage: circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}.
  - rd_ptr/wr_ptr are log2(DEPTH) bits and wrap naturally.
  - count is a separate register, 0..DEPTH.
- Fetch PC register `fpc`:
  - `mem_addr = fpc`.
  - Increments by 4 (mod 2^32) on each completed transfer.
  - Wraps 32'hFFFF_FFFC -> 0 with no special handling.
- FSM states:
  - RUN: `mem_req = (count < DEPTH)`. When count reaches DEPTH -> FULL.
  - FULL: `mem_req = 0`. On a pop -> RUN.
  - REDIR: entered on `pc_src`; lasts one cycle, `mem_req = 0`, then -> RUN.
- Push: on a completed transfer, {fpc, mem_rdata} is written at wr_ptr.
- Pop: when `if_valid && if_ready`. `if_valid = (count != 0)` and not masked by `pc_src`.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal only in RUN (count < DEPTH).
- Redirect (`pc_src = 1` in any state):
  - `mem_req` and `if_valid` are forced low combinationally in that cycle; any `mem_ack` that cycle is ignored.
  - Next edge: count <= 0, rd_ptr <= wr_ptr, `fpc <= {pc_addr[31:2], 2'b00}`, state <= REDIR.
  - Redirect has priority over push and pop.
- `pc_src` while already in REDIR re-applies the redirect, and the latest target wins.
- `mem_ack` without `mem_req` is ignored.

## Timing
- Reset (async assert, sync-free deassert path):
  - state=RUN, count=0, pointers=0, fpc=RESET_PC.
  - Outputs: `mem_req=1`, `mem_addr=RESET_PC`, `if_valid=0`, `if_instr=0`, `if_pc=0`, `q_count=0`.
- Reset asserted mid-transfer: the transfer is abandoned and no entry is written.
- Ack-to-valid latency: 1 cycle without bypass (word acked on edge N is visible at `if_valid` after edge N).
- Throughput: one word per cycle with zero-wait memory and `if_ready` held high.
- Redirect-to-first-request: `pc_src` at cycle N, REDIR at N+1, `mem_req` with the new address at N+2.
- Empty output: when `if_valid=0`, `if_instr` and `if_pc` hold their last values (0 after reset).

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When count==0 and a transfer completes, the word is presented on `if_instr`/`if_pc` with `if_valid=1` combinationally in the same cycle.
  - If `if_ready` is also high, the word is consumed and not stored (count stays 0). Otherwise it is stored normally.
  - Redirect masking still applies.
- Undefined: no mem-to-IF combinational path; latency is fixed at 1 cycle.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory, `if_ready=1` -> `if_pc` sequence 100,104,108,… one per cycle from the 2nd cycle after reset release; `mem_addr` starts at 100.
- `if_ready=0`, DEPTH=4 -> exactly 4 acks accepted (`q_count=4`), `mem_req` drops; one pop -> `mem_req` high the next cycle, `q_count` returns to 4.
- Queue holding 3 words, `pc_src=1`, `pc_addr=32'h2003` -> `if_valid=0` that cycle, `q_count=0` next, `mem_addr=32'h2000` two cycles after the strobe, stale words never popped.
- `mem_ack` arriving in the same cycle as `pc_src` -> that word is discarded and `fpc` equals the target, not old+4.
- `fpc=32'hFFFF_FFF8`, two acks -> `if_pc` FFFF_FFF8, FFFF_FFFC, then `mem_addr=0`.
- With `IFQ_BYPASS_EN`, empty queue, ack with `mem_rdata=32'h2008_0005` and `if_ready=1` -> `if_valid=1`, `if_instr=32'h2008_0005` in the ack cycle, `q_count` stays 0.
